// File: rtl/comparator_pkg.sv
// Shared types for the sequential branch comparator: relation codes, FSM states
// and the relation-decode helper.
package comparator_pkg;

    typedef enum logic [2:0] {
        BEQ  = 3'b000,
        BNE  = 3'b001,
        BLT  = 3'b100,
        BGE  = 3'b101,
        BLTU = 3'b110,
        BGEU = 3'b111
    } cmp_op_t;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    // Signed relations are reduced to unsigned ones by flipping operand MSBs at accept.
    function automatic logic is_signed_op(input logic [2:0] op);
        return (op[2:1] == 2'b10);
    endfunction

    function automatic logic cmp_result(input logic [2:0] op, input logic eq, input logic lt);
        case (op)
            BEQ:     return eq;
            BNE:     return ~eq;
            BLT:     return lt;
            BLTU:    return lt;
            BGE:     return ~lt;
            BGEU:    return ~lt;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/comparator_chunk.sv
// Combinational unsigned equality / less-than for one W-bit slice, built from
// per-bit compares with MSB priority.
module comparator_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic         eq,
    output logic         lt
);

    logic [W-1:0] bit_eq;
    logic [W-1:0] bit_lt;

    assign bit_eq = x ~^ y;
    assign bit_lt = ~x & y;
    assign eq     = &bit_eq;

    // NOTE: blocking assignments here build a ripple chain; each step reads the value just computed.
    always_comb begin
        lt = 1'b0;
        for (int i = 0; i < W; i++) begin
            lt = bit_lt[i] | (bit_eq[i] & lt);
        end
    end

endmodule

// File: rtl/comparator_seq.sv
// Multi-cycle branch-condition comparator scanning CHUNK bits per cycle, MSB first.
// Define COMPARATOR_SEQ_EARLY_EXIT_EN to stop at the first differing chunk; otherwise constant time.
module comparator_seq
    import comparator_pkg::*;
#(
    parameter int N     = 32,
    parameter int CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic [2:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         result,
    output logic         busy
);

    localparam int NCH   = N / CHUNK;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [N-1:0] MSB_MASK = N'(1) << (N - 1);

    if (N % CHUNK != 0) begin : g_chunk_check
        $error("comparator_seq: N (%0d) must be a multiple of CHUNK (%0d)", N, CHUNK);
    end

    state_t             state_q, state_d;
    logic [N-1:0]       a_q, b_q;
    logic [2:0]         op_q;
    logic [IDX_W-1:0]   idx_q;
    logic               result_q;
    logic [CHUNK-1:0]   a_sel, b_sel;
    logic               chunk_eq, chunk_lt;
    logic               idx_zero;
    logic               scan_last, scan_eq, scan_lt;

    assign a_sel    = a_q[int'(idx_q) * CHUNK +: CHUNK];
    assign b_sel    = b_q[int'(idx_q) * CHUNK +: CHUNK];
    assign idx_zero = (idx_q == '0);

    comparator_chunk #(.W(CHUNK)) u_chunk (
        .x  (a_sel),
        .y  (b_sel),
        .eq (chunk_eq),
        .lt (chunk_lt)
    );

`ifdef COMPARATOR_SEQ_EARLY_EXIT_EN
    assign scan_last = idx_zero || !chunk_eq;
    assign scan_eq   = chunk_eq;
    assign scan_lt   = chunk_lt;
`else
    logic found_q, lt_q;

    // Once a difference is seen, the remaining chunks only burn time.
    assign scan_last = idx_zero;
    assign scan_eq   = !found_q && chunk_eq;
    assign scan_lt   = found_q ? lt_q : chunk_lt;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (in_valid)  state_d = SCAN;
            SCAN:    if (scan_last) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE:    in_ready = 1'b1;
            SCAN:    busy = 1'b1;
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            idx_q    <= '0;
            result_q <= 1'b0;
`ifndef COMPARATOR_SEQ_EARLY_EXIT_EN
            found_q  <= 1'b0;
            lt_q     <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= is_signed_op(op) ? (a ^ MSB_MASK) : a;
                        b_q   <= is_signed_op(op) ? (b ^ MSB_MASK) : b;
                        op_q  <= op;
                        idx_q <= IDX_W'(NCH - 1);
`ifndef COMPARATOR_SEQ_EARLY_EXIT_EN
                        found_q <= 1'b0;
                        lt_q    <= 1'b0;
`endif
                    end
                end
                SCAN: begin
                    if (scan_last) begin
                        result_q <= cmp_result(op_q, scan_eq, scan_lt);
                    end else begin
                        idx_q <= idx_q - IDX_W'(1);
`ifndef COMPARATOR_SEQ_EARLY_EXIT_EN
                        if (!found_q && !chunk_eq) begin
                            found_q <= 1'b1;
                            lt_q    <= chunk_lt;
                        end
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_comparator_seq.sv
// Directed bench for comparator_seq (N=32, CHUNK=8); expected latency follows
// whether COMPARATOR_SEQ_EARLY_EXIT_EN is defined for the build.
module tb_comparator_seq;
    import comparator_pkg::*;

    localparam int N     = 32;
    localparam int CHUNK = 8;
    localparam int NCH   = N / CHUNK;
`ifdef COMPARATOR_SEQ_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        string tag;
        logic  res;
        int    k;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [2:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic         result;
    logic         busy;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    comparator_seq #(.N(N), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic model_res(input logic [2:0] o, input logic [N-1:0] x, input logic [N-1:0] y);
        case (o)
            3'b000:  return x == y;
            3'b001:  return x != y;
            3'b100:  return $signed(x) < $signed(y);
            3'b101:  return $signed(x) >= $signed(y);
            3'b110:  return x < y;
            3'b111:  return x >= y;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int model_k(input logic [N-1:0] x, input logic [N-1:0] y);
        int k = NCH;
        bit found = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (!found && (x[i*CHUNK +: CHUNK] != y[i*CHUNK +: CHUNK])) begin
                found = 1'b1;
                if (EARLY) k = NCH - i;
            end
        end
        return k;
    endfunction

    // Present one operation, push its expectation, and scramble inputs after the accept edge.
    task automatic issue(input logic [2:0] o, input logic [N-1:0] x, input logic [N-1:0] y, input string tag);
        exp_t e;
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check({tag, " in_ready timeout"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a  = x;
        b  = y;
        op = o;
        e.tag = tag;
        e.res = model_res(o, x, y);
        e.k   = model_k(x, y);
        sb.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a  = $urandom;
        b  = $urandom;
        op = 3'($urandom);
        check({tag, " in_ready after accept"}, 32'(in_ready), 32'd0);
    endtask

    task automatic collect(output logic res_seen);
        exp_t e;
        int edges = 0;
        while (!out_valid && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        res_seen = result;
        if (sb.size() == 0) begin
            check("scoreboard underflow", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check({e.tag, " latency"}, 32'(edges), 32'(e.k));
            check({e.tag, " result"}, 32'(result), 32'(e.res));
        end
    endtask

    task automatic run(input logic [2:0] o, input logic [N-1:0] x, input logic [N-1:0] y, input string tag);
        logic r;
        issue(o, x, y, tag);
        collect(r);
        @(posedge clk);
        #1;
        check({tag, " out_valid drop"}, 32'(out_valid), 32'd0);
        check({tag, " in_ready back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic         held;
        logic         seen;
        logic [N-1:0] x;
        logic [N-1:0] y;

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        op        = 3'b000;
        out_ready = 1'b1;
        #12;
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset result", 32'(result), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run(BEQ,  32'h12345678, 32'h12345678, "beq_equal");
        run(BNE,  32'h12345678, 32'h12345678, "bne_equal");
        run(BLT,  32'hFFFFFFFF, 32'h00000001, "blt_neg");
        run(BLTU, 32'hFFFFFFFF, 32'h00000001, "bltu_big");
        run(BGE,  32'h80000000, 32'h7FFFFFFF, "bge_min");
        run(BGEU, 32'h80000000, 32'h7FFFFFFF, "bgeu_min");
        run(BGE,  32'h00001200, 32'h00001100, "bge_chunk1");
        run(BLTU, 32'h000000FE, 32'h000000FF, "bltu_lsb");
        run(BGE,  32'hFFFFFF80, 32'hFFFFFF80, "bge_equal_neg");
        run(3'b010, 32'h0, 32'h0, "illegal_010");
        run(3'b011, 32'h5, 32'h3, "illegal_011");

        for (int i = 0; i < 6; i++) begin
            x = $urandom;
            y = x;
            y[(i % NCH)*CHUNK +: CHUNK] = x[(i % NCH)*CHUNK +: CHUNK] ^ 8'($urandom_range(1, 255));
            run(3'(4 + (i % 4)), x, y, $sformatf("rand%0d", i));
        end

        // Backpressure: result held, new requests ignored while DONE.
        out_ready = 1'b0;
        issue(BLT, 32'h00001200, 32'h00001100, "bp");
        collect(held);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            op = BEQ;
            a  = $urandom;
            b  = a;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check($sformatf("bp out_valid %0d", i), 32'(out_valid), 32'd1);
            check($sformatf("bp result %0d", i), 32'(result), 32'd0);
            check($sformatf("bp in_ready %0d", i), 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp release out_valid", 32'(out_valid), 32'd0);
        check("bp release in_ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            seen = seen | out_valid | busy;
        end
        check("bp pulses ignored", 32'(seen), 32'd0);

        // Reset mid-scan discards the operation.
        issue(BEQ, 32'hCAFEF00D, 32'hCAFEF00D, "rst_mid");
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_mid out_valid", 32'(out_valid), 32'd0);
        check("rst_mid busy", 32'(busy), 32'd0);
        check("rst_mid in_ready", 32'(in_ready), 32'd1);
        void'(sb.pop_back());
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            seen = seen | out_valid;
        end
        check("rst_mid no result", 32'(seen), 32'd0);
        run(BLTU, 32'h00010000, 32'h00020000, "after_rst");

        check("scoreboard empty", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/comparator_seq.md
Name: comparator_seq

Overview:
- Multi-cycle, parametrised magnitude/equality comparator; successor to the single-cycle N-bit equality comparator.
- Evaluates one of six branch-style relations (RISC-V funct3 encoding) on two N-bit operands.
- Scans CHUNK bits per cycle, MSB chunk first, with valid/ready handshakes on input and output.
- Intended as the branch-condition unit of the multicycle core; trades latency for area.

Parameters:
- N, 32, operand width in bits.
- CHUNK, 8, bits compared per scan cycle. N must be a multiple of CHUNK; otherwise elaboration fails with $error.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands/op presented.
- in_ready  output  1  block can accept; high only in IDLE.
- a  input  N  operand A.
- b  input  N  operand B.
- op  input  3  cmp_op_t relation select.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  1  relation outcome.
- busy  output  1  high in SCAN or DONE.

Behaviour:
- Reset (async, any state): state=IDLE; out_valid=0; result=0; busy=0; in_ready=1; operand/op/index/flag registers cleared. Any in-flight comparison is discarded and no result is produced.
- States:
  - IDLE: on in_valid&&in_ready, register a, b, op. For signed ops (BLT/BGE), register a[N-1] and b[N-1] inverted so that all later comparisons are unsigned. Set idx=N/CHUNK-1 and go to SCAN.
  - SCAN: compare chunk idx of the registered operands.
    - Chunks differ: latch lt=chunk_lt, eq=0, go to DONE.
    - Chunks equal and idx==0: eq=1, lt=0, go to DONE.
    - Otherwise: idx decrements.
  - DONE: out_valid=1. result is registered and valid on out_valid's first cycle:
    - BEQ=eq; BNE=~eq; BLT/BLTU=lt; BGE/BGEU=~lt.
    - Illegal codes 010/011 give result=0.
    - On out_ready go to IDLE. out_valid falls on that edge.
- Latency: out_valid rises k clock edges after the accept edge.
  - k = number of chunks scanned: first-differing-chunk position from the MSB, 1-based, or N/CHUNK if all chunks are equal.
  - When CHUNK==N, k=1.
- No overlap: a new operation is accepted only in IDLE.
  - Minimum initiation interval is k+2 cycles with out_ready held high.
- Operands and op are sampled only at accept; input changes afterwards have no effect.
- out_valid and result hold stable while out_ready is low.
- in_valid is ignored while in_ready=0.
- idx width is max(1,$clog2(N/CHUNK)). idx never wraps below 0.

Optional Feature:
- Macro: COMPARATOR_SEQ_EARLY_EXIT_EN.
- Defined: early termination on the first differing chunk, as described above.
- Undefined: constant-time mode.
  - SCAN always runs all N/CHUNK chunks, so k=N/CHUNK.
  - Only the first differing chunk's lt is latched; later chunks are ignored after a difference.
  - Results are identical in both modes; only latency differs.

Decomposition:
- Package comparator_pkg:
  - typedef enum logic [2:0] cmp_op_t: BEQ=000, BNE=001, BLT=100, BGE=101, BLTU=110, BGEU=111.
  - typedef enum state_t {IDLE, SCAN, DONE}.
- Sub-module comparator_chunk (parameter W=CHUNK):
  - Purely combinational; outputs eq = &(x ~^ y) and lt (unsigned x<y) for one slice.
  - Built structurally from bitwise compare, MSB-priority.
  - Instantiated once, with its inputs muxed by idx.

Test Plan (N=32, CHUNK=8, early exit enabled unless noted):
- BEQ a=0x12345678 b=0x12345678 -> result=1, out_valid 4 edges after accept. BNE with the same operands -> 0.
- BLT a=0xFFFFFFFF b=0x00000001 -> result=1 after 1 cycle. BLTU with the same operands -> 0. With the macro undefined, both results are unchanged, latency 4.
- BGE a=0x80000000 b=0x7FFFFFFF -> 0. BGEU -> 1. BGE a=0x00001200 b=0x00001100 -> 1, latency 3.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_valid/result stable, in_ready=0, in_valid pulses ignored. Raise out_ready -> IDLE next edge, in_ready=1.
- Reset mid-SCAN (assert rst at scan cycle 2, asynchronous mid-cycle) -> out_valid=0, busy=0, in_ready=1 immediately. No result after release. Next op completes correctly.
- Illegal op=3'b010, a=b=0 -> out_valid after 4 cycles, result=0.
